// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intc_pkg
//  Description : Shared constants and types for the interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package intc_pkg;

    localparam logic [31:0] C_EN_ADDR   = 32'hF000_0800;
    localparam logic [31:0] C_PEND_ADDR = 32'hF000_0804;
    localparam logic [31:0] C_ID_ADDR   = 32'hF000_0808;
    localparam logic [31:0] C_EOI_ADDR  = 32'hF000_080C;

    localparam int C_GIE_BIT   = 31;
    localparam int C_VALID_BIT = 31;
    localparam int C_SPUR_BITS = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } intc_state_e;

endpackage
`default_nettype wire

// File: rtl/intc_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : intc_prio_enc
//  Description : Fixed-priority encoder, lowest set index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module intc_prio_enc #(
    parameter int NDEV   = 4,
    parameter int IDBITS = 2
) (
    input  logic [NDEV-1:0]   i_req,
    output logic              o_any,
    output logic [IDBITS-1:0] o_idx
);

    // Scan from the top so the last hit (lowest index) is kept.
    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDBITS'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/intr_controller.sv
`default_nettype none
// ============================================================================
//  Module      : intr_controller
//  Description : Memory-mapped, prioritised interrupt controller with
//                raise / acknowledge / end-of-interrupt handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module intr_controller
    import intc_pkg::*;
#(
    parameter int               DBITS     = 32,
    parameter int               NDEV      = 4,
    parameter int               IDBITS    = 2,
    parameter logic [DBITS-1:0] EN_ADDR   = DBITS'(C_EN_ADDR),
    parameter logic [DBITS-1:0] PEND_ADDR = DBITS'(C_PEND_ADDR),
    parameter logic [DBITS-1:0] ID_ADDR   = DBITS'(C_ID_ADDR),
    parameter logic [DBITS-1:0] EOI_ADDR  = DBITS'(C_EOI_ADDR)
) (
    input  logic              clk,
    input  logic              init,
    input  logic [DBITS-1:0]  abus,
    inout  wire  [DBITS-1:0]  dbus,
    input  logic              we,
    input  logic [NDEV-1:0]   irq_in,
    output logic              intr_cpu,
    output logic [IDBITS-1:0] intr_id,
    input  logic              iack_cpu
);

    intc_state_e            r_state_q,    w_state_d;
    logic [NDEV-1:0]        r_irq_q,      w_irq_d;
    logic [NDEV-1:0]        r_mask_q,     w_mask_d;
    logic                   r_gie_q,      w_gie_d;
    logic [IDBITS-1:0]      r_cur_id_q,   w_cur_id_d;
    logic [C_SPUR_BITS-1:0] r_spur_cnt_q, w_spur_cnt_d;

    logic [NDEV-1:0]   w_req;
    logic              w_req_any;
    logic [IDBITS-1:0] w_best;
    logic              w_en_wr;
    logic              w_eoi_wr;
    logic              w_rd_hit;
    logic [DBITS-1:0]  w_rdata;
    logic              w_unused;

    assign w_req    = r_gie_q ? (r_irq_q & r_mask_q) : '0;
    assign w_en_wr  = we && (abus == EN_ADDR);
    assign w_eoi_wr = we && (abus == EOI_ADDR);
    assign w_unused = ^dbus[C_GIE_BIT-1:NDEV];

    intc_prio_enc #(
        .NDEV   (NDEV),
        .IDBITS (IDBITS)
    ) u_prio_enc (
        .i_req (w_req),
        .o_any (w_req_any),
        .o_idx (w_best)
    );

    always_comb begin
        w_irq_d  = irq_in;
        w_mask_d = r_mask_q;
        w_gie_d  = r_gie_q;
        if (w_en_wr) begin
            w_mask_d = dbus[NDEV-1:0];
            w_gie_d  = dbus[C_GIE_BIT];
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_cur_id_d   = r_cur_id_q;
        w_spur_cnt_d = r_spur_cnt_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_req_any) begin
                    w_state_d  = S_ASSERT;
                    w_cur_id_d = w_best;
                end
            end
            S_ASSERT: begin
                // Request vanished before acknowledge: spurious, even if iack arrives now.
                if (!w_req_any) begin
                    w_state_d = S_IDLE;
                    if (r_spur_cnt_q != '1) begin
                        w_spur_cnt_d = r_spur_cnt_q + 1'b1;
                    end
                end else begin
                    w_cur_id_d = w_best;
                    if (iack_cpu) begin
                        w_state_d = S_SERVICE;
                    end
                end
            end
            S_SERVICE: begin
                if (w_eoi_wr) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state_q    <= S_IDLE;
            r_irq_q      <= '0;
            r_mask_q     <= '0;
            r_gie_q      <= 1'b0;
            r_cur_id_q   <= '0;
            r_spur_cnt_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_irq_q      <= w_irq_d;
            r_mask_q     <= w_mask_d;
            r_gie_q      <= w_gie_d;
            r_cur_id_q   <= w_cur_id_d;
            r_spur_cnt_q <= w_spur_cnt_d;
        end
    end

    always_comb begin
        w_rd_hit = 1'b0;
        w_rdata  = '0;
        if (!we) begin
            if (abus == EN_ADDR) begin
                w_rd_hit                = 1'b1;
                w_rdata[NDEV-1:0]       = r_mask_q;
                w_rdata[C_GIE_BIT]      = r_gie_q;
            end else if (abus == PEND_ADDR) begin
                w_rd_hit                = 1'b1;
                w_rdata[NDEV-1:0]       = r_irq_q & r_mask_q;
            end else if (abus == ID_ADDR) begin
                w_rd_hit = 1'b1;
                if ((r_state_q == S_ASSERT) || (r_state_q == S_SERVICE)) begin
                    w_rdata[C_VALID_BIT]  = 1'b1;
                    w_rdata[IDBITS-1:0]   = r_cur_id_q;
                end
            end else if (abus == EOI_ADDR) begin
                w_rd_hit                  = 1'b1;
                w_rdata[C_SPUR_BITS-1:0]  = r_spur_cnt_q;
            end
        end
    end

    assign dbus     = w_rd_hit ? w_rdata : 'z;
    assign intr_cpu = (r_state_q == S_ASSERT);
    assign intr_id  = r_cur_id_q;

endmodule
`default_nettype wire

// File: tb/tb_intr_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intr_controller
//  Description : Directed self-checking bench for intr_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_controller;

    localparam logic [31:0] C_EN   = 32'hF000_0800;
    localparam logic [31:0] C_PEND = 32'hF000_0804;
    localparam logic [31:0] C_ID   = 32'hF000_0808;
    localparam logic [31:0] C_EOI  = 32'hF000_080C;

    logic        clk = 1'b0;
    logic        init;
    logic [31:0] abus;
    wire  [31:0] dbus;
    logic        we;
    logic [3:0]  irq_in;
    logic        intr_cpu;
    logic [1:0]  intr_id;
    logic        iack_cpu;

    logic        r_tb_drv;
    logic [31:0] r_tb_dout;
    logic [31:0] r_rd;
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    assign dbus = r_tb_drv ? r_tb_dout : 'z;

    always #5 clk = ~clk;

    intr_controller u_dut (
        .clk      (clk),
        .init     (init),
        .abus     (abus),
        .dbus     (dbus),
        .we       (we),
        .irq_in   (irq_in),
        .intr_cpu (intr_cpu),
        .intr_id  (intr_id),
        .iack_cpu (iack_cpu)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        abus      = addr;
        we        = 1'b1;
        r_tb_dout = data;
        r_tb_drv  = 1'b1;
        tick();
        we        = 1'b0;
        r_tb_drv  = 1'b0;
        abus      = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        abus = addr;
        we   = 1'b0;
        #1;
        data = dbus;
        abus = '0;
    endtask

    task automatic check_cpu(input string tag, input logic exp_cpu, input logic [1:0] exp_id);
        expect_val({31'b0, exp_cpu});
        check({tag, "_cpu"}, {31'b0, intr_cpu});
        expect_val({30'b0, exp_id});
        check({tag, "_id"}, {30'b0, intr_id});
    endtask

    task automatic check_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp_v);
        expect_val(exp_v);
        bus_read(addr, r_rd);
        check(tag, r_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init      = 1'b1;
        abus      = '0;
        we        = 1'b0;
        irq_in    = '0;
        iack_cpu  = 1'b0;
        r_tb_drv  = 1'b0;
        r_tb_dout = '0;
        repeat (2) tick();
        init = 1'b0;

        // Reset state
        check_cpu("rst", 1'b0, 2'd0);
        check_reg("rst_en", C_EN, 32'h0);
        check_reg("rst_id", C_ID, 32'h0);
        check_reg("rst_eoi", C_EOI, 32'h0);

        // Basic raise / ack / EOI on source 2
        bus_write(C_EN, 32'h8000_0004);
        irq_in = 4'b0100;
        tick();
        check_cpu("basic_edge1", 1'b0, 2'd0);
        tick();
        check_cpu("basic_raise", 1'b1, 2'd2);
        check_reg("basic_id_assert", C_ID, 32'h8000_0002);
        iack_cpu = 1'b1;
        tick();
        iack_cpu = 1'b0;
        check_cpu("basic_service", 1'b0, 2'd2);
        check_reg("basic_id_service", C_ID, 32'h8000_0002);
        irq_in = 4'b0000;
        tick();
        bus_write(C_EOI, 32'h0);
        tick();
        tick();
        check_cpu("basic_idle", 1'b0, 2'd2);
        check_reg("basic_id_idle", C_ID, 32'h0);

        // Priority and preemption
        bus_write(C_EN, 32'h8000_000F);
        irq_in = 4'b1000;
        tick();
        tick();
        check_cpu("prio_raise3", 1'b1, 2'd3);
        irq_in = 4'b1010;
        tick();
        tick();
        check_cpu("prio_preempt", 1'b1, 2'd1);
        iack_cpu = 1'b1;
        tick();
        iack_cpu = 1'b0;
        irq_in = 4'b1011;
        tick();
        tick();
        check_cpu("prio_frozen", 1'b0, 2'd1);
        check_reg("prio_id_frozen", C_ID, 32'h8000_0001);
        bus_write(C_EOI, 32'h0);
        check_cpu("prio_eoi_gap", 1'b0, 2'd1);
        tick();
        check_cpu("prio_next0", 1'b1, 2'd0);
        iack_cpu = 1'b1;
        tick();
        iack_cpu = 1'b0;
        irq_in = 4'b0000;
        tick();
        bus_write(C_EOI, 32'h0);
        tick();
        check_reg("prio_spur0", C_EOI, 32'h0);

        // Spurious: request drops before acknowledge
        irq_in = 4'b0100;
        tick();
        tick();
        irq_in = 4'b0000;
        tick();
        check_cpu("spur_still_assert", 1'b1, 2'd2);
        tick();
        check_cpu("spur_idle", 1'b0, 2'd2);
        check_reg("spur_cnt1", C_EOI, 32'h1);

        // iack in the same cycle the request disappears: spurious wins
        irq_in = 4'b0100;
        tick();
        tick();
        irq_in = 4'b0000;
        tick();
        iack_cpu = 1'b1;
        tick();
        iack_cpu = 1'b0;
        check_cpu("spur_iack", 1'b0, 2'd2);
        check_reg("spur_iack_id", C_ID, 32'h0);
        check_reg("spur_cnt2", C_EOI, 32'h2);

        for (int i = 0; i < 300; i++) begin
            irq_in = 4'b0100;
            tick();
            tick();
            irq_in = 4'b0000;
            tick();
            tick();
        end
        check_reg("spur_sat", C_EOI, 32'h0000_00FF);

        // Mask / GIE
        bus_write(C_EN, 32'h0000_000F);
        irq_in = 4'b1111;
        repeat (3) tick();
        check_cpu("gie_off", 1'b0, 2'd2);
        check_reg("pend_all", C_PEND, 32'h0000_000F);
        bus_write(C_EN, 32'h0000_0005);
        check_reg("pend_masked", C_PEND, 32'h0000_0005);
        check_reg("en_readback", C_EN, 32'h0000_0005);
        bus_write(C_EN, 32'h8000_000F);
        check_cpu("gie_on_same", 1'b0, 2'd2);
        tick();
        check_cpu("gie_on_raise", 1'b1, 2'd0);

        // Held level through EOI; masking the serviced source keeps SERVICE
        iack_cpu = 1'b1;
        tick();
        iack_cpu = 1'b0;
        bus_write(C_EN, 32'h8000_000E);
        tick();
        check_cpu("mask_in_service", 1'b0, 2'd0);
        check_reg("mask_in_service_id", C_ID, 32'h8000_0000);
        bus_write(C_EN, 32'h8000_000F);
        bus_write(C_EOI, 32'h0);
        check_cpu("held_gap", 1'b0, 2'd0);
        tick();
        check_cpu("held_reraise", 1'b1, 2'd0);
        bus_write(C_EOI, 32'h0);
        check_cpu("eoi_in_assert", 1'b1, 2'd0);
        bus_write(C_EN, 32'h0000_000F);
        tick();
        check_cpu("gie_drop_idle", 1'b0, 2'd0);
        bus_write(C_EOI, 32'h0);
        tick();
        check_cpu("eoi_in_idle", 1'b0, 2'd0);
        check_reg("eoi_in_idle_id", C_ID, 32'h0);
        check_reg("eoi_in_idle_cnt", C_EOI, 32'h0000_00FF);

        // Asynchronous reset while ASSERT
        bus_write(C_EN, 32'h8000_000F);
        tick();
        check_cpu("pre_reset", 1'b1, 2'd0);
        irq_in = 4'b0010;
        tick();
        tick();
        check_cpu("pre_reset_id1", 1'b1, 2'd1);
        #2;
        init = 1'b1;
        #1;
        check_cpu("async_rst", 1'b0, 2'd0);
        check_reg("async_rst_en", C_EN, 32'h0);
        check_reg("async_rst_id", C_ID, 32'h0);
        check_reg("async_rst_eoi", C_EOI, 32'h0);
        init = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
